// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide sequencer for EX (clk, rst_n, valid, funct3, rs1_data, rs2_data, flush -> stall, result, result_valid)
module mdu_sequencer #(
  parameter int XLEN = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op;
  logic neg, accept, busy, last, sa, sb, div_zero, div_ovf, special;
  logic [XLEN-1:0] opd, acc, lo, acc_n, lo_n, ma, mb, spec_res, fin, res;
  logic [XLEN:0] sum, shl, diff;
  logic [2*XLEN-1:0] prod, full;
  assign accept = state == IDLE && valid && !flush;
  assign busy = state == MUL || state == DIV;
  assign last = cnt == CNT_W'(XLEN - 1);
  assign stall = rst_n && (accept || busy);
  assign result = res;
  assign result_valid = state == DONE;
  assign sa = (funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10)) && rs1_data[XLEN-1];
  assign sb = (funct3[2] ? !funct3[0] : funct3[1:0] == 2'b01) && rs2_data[XLEN-1];
  assign ma = sa ? -rs1_data : rs1_data;
  assign mb = sb ? -rs2_data : rs2_data;
  assign div_zero = rs2_data == '0;
  assign div_ovf = !funct3[0] && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && &rs2_data;
  assign special = funct3[2] && (div_zero || div_ovf);
  assign spec_res = div_zero ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : rs1_data);
  // acc/lo hold the product halves in MUL and remainder/quotient in DIV
  assign sum = {1'b0, acc} + (lo[0] ? {1'b0, opd} : '0);
  assign shl = {acc, lo[XLEN-1]};
  assign diff = shl - {1'b0, opd};
  assign acc_n = state == MUL ? sum[XLEN:1] : diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
  assign lo_n = state == MUL ? {sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], !diff[XLEN]};
  assign prod = {acc_n, lo_n};
  assign full = neg ? -prod : prod;
  assign fin = state == MUL ? (op == 2'b00 ? full[XLEN-1:0] : full[2*XLEN-1:XLEN])
             : op[1] ? (neg ? -acc_n : acc_n) : (neg ? -lo_n : lo_n);
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (state == IDLE && valid) state_n = !funct3[2] ? MUL : special ? DONE : DIV;
    else if (busy && last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      neg <= 1'b0;
      opd <= '0;
      acc <= '0;
      lo <= '0;
      res <= '0;
    end else begin
      state <= state_n;
      cnt <= busy && !flush && !last ? cnt + 1'b1 : '0;
      res <= flush ? '0 : accept && special ? spec_res : busy && last ? fin : '0;
      if (accept) begin
        op <= funct3[1:0];
        neg <= funct3[2] && funct3[1] ? sa : sa ^ sb;
        opd <= funct3[2] ? mb : ma;
        acc <= '0;
        lo <= funct3[2] ? ma : mb;
      end else if (busy) begin
        acc <= acc_n;
        lo <= lo_n;
      end
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus random checks of mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;
  logic clk = 0, rst_n = 0, valid = 0, flush = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0, result;
  logic stall, result_valid;
  int n_cmp = 0, n_err = 0;
  mdu_sequencer dut (.clk(clk), .rst_n(rst_n), .valid(valid), .funct3(funct3), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .flush(flush), .stall(stall), .result(result), .result_valid(result_valid));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic ovf;
    ovf = a == 32'h8000_0000 && b == 32'hffff_ffff;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[63:32]; end
      3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'd0, b})); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return b == 0 ? 32'hffff_ffff : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hffff_ffff : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n, bad;
    logic sp;
    sp = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
    valid = 1; funct3 = f; rs1_data = a; rs2_data = b;
    @(negedge clk);
    check({tag, "_accept_stall"}, 32'(stall), 1);
    check({tag, "_accept_rv"}, 32'(result_valid), 0);
    n = 0; bad = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (result_valid) break;
      if (stall !== 1'b1) bad++;
    end
    check({tag, "_busy_stall_low"}, 32'(bad), 0);
    check({tag, "_latency"}, 32'(n), sp ? 1 : 33);
    check({tag, "_result"}, result, exp);
    check({tag, "_done_stall"}, 32'(stall), 0);
    @(posedge clk); #1;
    valid = 0;
  endtask
  initial begin
    int rv_cnt;
    logic [2:0] f;
    logic [31:0] a, b;
    @(negedge clk);
    check("reset_stall", 32'(stall), 0);
    check("reset_result", result, 0);
    check("reset_rv", 32'(result_valid), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run_op("mul_neg", 3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    run_op("div_neg", 3'd4, -32'd100, 32'd7, 32'hffff_fff2);
    run_op("rem_neg", 3'd6, -32'd100, 32'd7, 32'hffff_fffe);
    run_op("div_zero", 3'd4, 32'd5, 32'd0, 32'hffff_ffff);
    run_op("remu_zero", 3'd7, 32'd5, 32'd0, 32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0);
    valid = 1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6;
    repeat (11) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0; valid = 0;
    @(negedge clk);
    check("flush_stall", 32'(stall), 0);
    rv_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
    end
    check("flush_no_rv", 32'(rv_cnt), 0);
    @(posedge clk); #1;
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12);
    valid = 1; funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd3;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 0; valid = 0;
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_result", result, 0);
    check("rst_rv", 32'(result_valid), 0);
    @(posedge clk); #1;
    rst_n = 1;
    run_op("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hffff_ffff; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", f, a, b, model(f, a, b));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
